// File: rtl/mini_alu_pkg.sv
// Shared types and constants for the mini ALU scheduler.
// Opcodes, scheduler states and the latched command bundle.
package mini_alu_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MUL = 8'h03;
  localparam logic [7:0] OP_DIV = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_NOT = 8'h08;
  localparam logic [7:0] OP_SHL = 8'h09;
  localparam logic [7:0] OP_SHR = 8'h0A;
  localparam logic [7:0] OP_ROL = 8'h0B;
  localparam logic [7:0] OP_ROR = 8'h0C;
  localparam logic [7:0] OP_INC = 8'h0D;
  localparam logic [7:0] OP_DEC = 8'h0E;
  localparam logic [7:0] OP_CMP = 8'h0F;

  localparam int DIV_LATENCY = 18;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WAIT_DIV,
    RESP
  } sched_state_t;

  typedef struct packed {
    logic        id;
    logic [7:0]  op;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [4:0]  shift;
  } cmd_t;

  function automatic logic op_legal(input logic [7:0] op);
    return (op[7:4] == 4'h0) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/mini_alu_16bit_sched_rr_arb_2.sv
// Two-way round-robin arbiter, one-hot grant.
// Pointer records the last winner and moves only on accept.
module rr_arb_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

  // Reset to "1 won last" so requester 0 goes first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/mini_alu_16bit_sched.sv
// Round-robin command scheduler in front of the 16-bit mini ALU.
// Optional DIV watchdog: define MINI_ALU_SCHED_TIMEOUT_EN.
module mini_alu_16bit_sched
  import mini_alu_pkg::*;
#(
  parameter int DIV_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][7:0]  req_op,
  input  logic [1:0][15:0] req_data0,
  input  logic [1:0][15:0] req_data1,
  input  logic [1:0][4:0]  req_shift,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic [7:0]       alu_op,
  output logic [15:0]      alu_data0,
  output logic [15:0]      alu_data1,
  output logic [4:0]       alu_num_shift,
  output logic             alu_div_start,
  input  logic [31:0]      alu_result,
  input  logic             alu_overflow,
  input  logic             alu_valid
);

  sched_state_t state;
  cmd_t         sel;
  logic [1:0]   grant;
  logic         accept;
  logic         cmd_id;
  logic         fin;
  logic         fin_ovf;
  logic         fin_err;
  logic [31:0]  fin_res;
  logic         div_expired;

  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (rst && state == IDLE) ? grant : 2'b00;

  rr_arb_2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    sel.id    = grant[1];
    sel.op    = req_op[grant[1]];
    sel.d0    = req_data0[grant[1]];
    sel.d1    = req_data1[grant[1]];
    sel.shift = req_shift[grant[1]];
  end

`ifdef MINI_ALU_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(DIV_TIMEOUT) + 1;
  logic [TW-1:0] div_cnt;

  assign div_expired = (div_cnt == TW'(DIV_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (state == ISSUE) begin
      div_cnt <= '0;
    end else if (state == WAIT_DIV && !alu_valid && !div_expired) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (DIV_TIMEOUT > 0);
  assign div_expired = 1'b0;
`endif

  // A late alu_valid beats the watchdog in the same cycle.
  always_comb begin
    fin     = 1'b0;
    fin_res = alu_result;
    fin_ovf = alu_overflow;
    fin_err = 1'b0;
    if (state == CAPTURE) begin
      fin = 1'b1;
    end else if (state == WAIT_DIV) begin
      if (alu_valid) begin
        fin = 1'b1;
      end else if (div_expired) begin
        fin     = 1'b1;
        fin_res = '0;
        fin_ovf = 1'b0;
        fin_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cmd_id        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_overflow  <= 1'b0;
      rsp_err       <= 1'b0;
      alu_op        <= OP_NOP;
      alu_data0     <= '0;
      alu_data1     <= '0;
      alu_num_shift <= '0;
      alu_div_start <= 1'b0;
    end else begin
      alu_div_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cmd_id <= sel.id;
            if (op_legal(sel.op)) begin
              state         <= ISSUE;
              alu_op        <= sel.op;
              alu_data0     <= sel.d0;
              alu_data1     <= sel.d1;
              alu_num_shift <= sel.shift;
              alu_div_start <= (sel.op == OP_DIV);
            end else begin
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_id       <= sel.id;
              rsp_result   <= '0;
              rsp_overflow <= 1'b0;
              rsp_err      <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state <= (alu_op == OP_DIV) ? WAIT_DIV : CAPTURE;
        end
        CAPTURE, WAIT_DIV: begin
          if (fin) begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_id        <= cmd_id;
            rsp_result    <= fin_res;
            rsp_overflow  <= fin_ovf;
            rsp_err       <= fin_err;
            alu_op        <= OP_NOP;
            alu_data0     <= '0;
            alu_data1     <= '0;
            alu_num_shift <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_alu_16bit_sched.sv
// Bench for mini_alu_16bit_sched with a behavioural ALU stub.
// Vector table plus hand sequences for stall, reset and arbitration.
module tb_mini_alu_16bit_sched;
  import mini_alu_pkg::*;

  localparam int TMO = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][7:0]  req_op;
  logic [1:0][15:0] req_data0;
  logic [1:0][15:0] req_data1;
  logic [1:0][4:0]  req_shift;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_result;
  logic             rsp_overflow;
  logic             rsp_err;
  logic [7:0]       alu_op;
  logic [15:0]      alu_data0;
  logic [15:0]      alu_data1;
  logic [4:0]       alu_num_shift;
  logic             alu_div_start;
  logic [31:0]      alu_result;
  logic             alu_overflow;
  logic             alu_valid;

  always #5 clk = ~clk;

  mini_alu_16bit_sched #(.DIV_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_data0     (req_data0),
    .req_data1     (req_data1),
    .req_shift     (req_shift),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_overflow  (rsp_overflow),
    .rsp_err       (rsp_err),
    .alu_op        (alu_op),
    .alu_data0     (alu_data0),
    .alu_data1     (alu_data1),
    .alu_num_shift (alu_num_shift),
    .alu_div_start (alu_div_start),
    .alu_result    (alu_result),
    .alu_overflow  (alu_overflow),
    .alu_valid     (alu_valid)
  );

  // ALU stub: registered result, DIV answers DIV_LATENCY cycles after start
  logic [31:0] res_q = '0;
  logic [31:0] div_q = '0;
  logic        ovf_q = 1'b0;
  logic        div_ovf = 1'b0;
  int          dcnt = 0;
  logic        stub_hang = 1'b0;
  logic [16:0] add_s;

  assign add_s = {1'b0, alu_data0} + {1'b0, alu_data1};

  always @(posedge clk) begin
    res_q <= '0;
    ovf_q <= 1'b0;
    case (alu_op)
      OP_ADD: begin
        res_q <= {16'h0, add_s[15:0]};
        ovf_q <= add_s[16];
      end
      OP_SUB: begin
        if (alu_data0 < alu_data1) begin
          res_q <= {16'h0, alu_data1 - alu_data0};
          ovf_q <= 1'b1;
        end else begin
          res_q <= {16'h0, alu_data0 - alu_data1};
        end
      end
      OP_MUL: res_q <= 32'(alu_data0) * 32'(alu_data1);
      OP_XOR: res_q <= {16'h0, alu_data0 ^ alu_data1};
      OP_SHL: res_q <= {16'h0, alu_data0} << alu_num_shift;
      OP_CMP: res_q <= {30'h0, alu_data0 < alu_data1,
                        alu_data0 == alu_data1};
      default: ;
    endcase
    if (alu_div_start) begin
      dcnt <= 1;
      if (alu_data1 == 16'h0) begin
        div_q   <= {16'hFFFF, alu_data0};
        div_ovf <= 1'b1;
      end else begin
        div_q   <= {alu_data0 / alu_data1, alu_data0 % alu_data1};
        div_ovf <= 1'b0;
      end
    end else if (dcnt == DIV_LATENCY) begin
      dcnt <= 0;
    end else if (dcnt != 0) begin
      dcnt <= dcnt + 1;
    end
  end

  assign alu_valid    = (dcnt == DIV_LATENCY) && !stub_hang;
  assign alu_result   = (dcnt != 0) ? div_q : res_q;
  assign alu_overflow = (dcnt != 0) ? div_ovf : ovf_q;

  typedef struct {
    logic        id;
    logic [7:0]  op;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t sb[$];
  exp_t exp_cur[2];
  bit   glog[$];
  vec_t vecs[11];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = -100;
  int   nfirst = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: pushes on accept, pops and compares on response handshake
  initial begin
    logic rsp_prev;
    int   dstarts;
    logic op_seen;
    exp_t e;
    rsp_prev = 1'b0;
    dstarts  = 0;
    op_seen  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rsp_prev = 1'b0;
      end else begin
        if (rsp_valid && !rsp_prev) begin
          nfirst++;
          if (sb.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 0);
          else chk("rsp_latency", 64'(cyc - sb[0].acc), 64'(sb[0].v.lat));
        end
        if (sb.size() > 0 && cyc == sb[0].acc + 1 && op_legal(sb[0].v.op))
          chk("issue_drive",
              {alu_op, alu_data0, alu_data1, alu_num_shift},
              {sb[0].v.op, sb[0].v.d0, sb[0].v.d1, sb[0].v.sh});
        if (alu_div_start) dstarts++;
        if (alu_op != OP_NOP) op_seen = 1'b1;
        if (rsp_valid && rsp_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_fields",
              {rsp_id, rsp_err, rsp_overflow, rsp_result},
              {e.v.id, e.v.err, e.v.ovf, e.v.res});
          chk("alu_use", {op_seen, dstarts[3:0]},
              {op_legal(e.v.op), 4'((e.v.op == OP_DIV) ? 1 : 0)});
          last_hs = cyc;
        end
        if (|(req_valid & req_ready)) begin
          chk("one_hot_ready", 64'($countones(req_ready)), 1);
          e     = exp_cur[req_ready[1]];
          e.acc = cyc;
          sb.push_back(e);
          glog.push_back(req_ready[1]);
          dstarts = 0;
          op_seen = 1'b0;
        end
        rsp_prev = rsp_valid;
      end
    end
  end

  task automatic drive(input vec_t v);
    exp_cur[v.id].v   = v;
    exp_cur[v.id].acc = 0;
    req_op[v.id]      = v.op;
    req_data0[v.id]   = v.d0;
    req_data1[v.id]   = v.d1;
    req_shift[v.id]   = v.sh;
    req_valid[v.id]   = 1'b1;
  endtask

  task automatic await_accept(input logic id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_valid[id] && req_ready[id]) && n < 60);
    chk("accept", 64'(req_ready[id]), 1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    await_accept(v.id);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 0);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rsp"},
        {req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err},
        '0);
    chk({tag, "_alu"},
        {alu_op, alu_data0, alu_data1, alu_num_shift, alu_div_start}, '0);
  endtask

  initial begin
    vec_t v;
    int   n;
    int   g0;
    int   nf0;
    req_valid = '0;
    req_op    = '0;
    req_data0 = '0;
    req_data1 = '0;
    req_shift = '0;
    rsp_ready = 1'b1;

    vecs[0]  = '{1'b0, OP_ADD, 16'h0003, 16'h0004, 5'd0, 32'h0000_0007, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b1, OP_DIV, 16'd100, 16'd7, 5'd0, {16'd14, 16'd2}, 1'b0, 1'b0, 20};
    vecs[2]  = '{1'b0, OP_MUL, 16'h1234, 16'h0010, 5'd0, 32'h0001_2340, 1'b0, 1'b0, 3};
    vecs[3]  = '{1'b1, OP_ADD, 16'hFFFF, 16'h0001, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 3};
    vecs[4]  = '{1'b0, OP_XOR, 16'hF0F0, 16'h0FF0, 5'd0, 32'h0000_FF00, 1'b0, 1'b0, 3};
    vecs[5]  = '{1'b1, 8'h20, 16'h1111, 16'h2222, 5'd3, 32'h0, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, OP_DIV, 16'd5, 16'd0, 5'd0, 32'hFFFF_0005, 1'b1, 1'b0, 20};
    vecs[7]  = '{1'b0, 8'h10, 16'h0001, 16'h0001, 5'd0, 32'h0, 1'b0, 1'b1, 1};
    vecs[8]  = '{1'b1, OP_CMP, 16'd7, 16'd7, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 3};
    vecs[9]  = '{1'b0, OP_NOP, 16'h0005, 16'h0006, 5'd0, 32'h0, 1'b0, 1'b1, 1};
    vecs[10] = '{1'b1, OP_SHL, 16'h8001, 16'h0000, 5'd4, 32'h0008_0010, 1'b0, 1'b0, 3};

    // reset state, with both requesters pushing to check req_ready stays low
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i]);
      wait_idle();
    end

    // backpressure: SUB held in RESP while requester 1 waits
    rsp_ready = 1'b0;
    v = '{1'b0, OP_SUB, 16'd5, 16'd9, 5'd0, 32'h0000_0004, 1'b1, 1'b0, 3};
    send(v);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    v = '{1'b1, OP_ADD, 16'd1, 16'd1, 5'd0, 32'h0000_0002, 1'b0, 1'b0, 3};
    drive(v);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold",
          {rsp_valid, rsp_id, rsp_err, rsp_overflow, rsp_result},
          {1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0004});
      chk("bp_req_ready", 64'(req_ready), 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[1] && n < 20);
    chk("bp_resume", 64'(cyc - last_hs), 1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_idle();

    // reset while waiting on the divider: no response may follow
    v = '{1'b0, OP_DIV, 16'd50, 16'd5, 5'd0, {16'd10, 16'd0}, 1'b0, 1'b0, 20};
    send(v);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset_mid");
    sb.delete();
    nf0 = nfirst;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_rsp_after_reset", 64'(nfirst - nf0), 0);
    @(posedge clk);
    #1;

    // both requesters streaming MULs: grants alternate from requester 0
    g0 = glog.size();
    v = '{1'b0, OP_MUL, 16'd3, 16'd5, 5'd0, 32'd15, 1'b0, 1'b0, 3};
    drive(v);
    v = '{1'b1, OP_MUL, 16'hFFFF, 16'hFFFF, 5'd0, 32'hFFFE_0001, 1'b0, 1'b0, 3};
    drive(v);
    n = 0;
    while (glog.size() < g0 + 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 req_valid = 2'b00;
    chk("alt_count", 64'(glog.size() - g0), 4);
    for (int i = 0; i < 4 && g0 + i < glog.size(); i++)
      chk("alt_grant", 64'(glog[g0 + i]), 64'(i % 2));
    wait_idle();

`ifdef MINI_ALU_SCHED_TIMEOUT_EN
    stub_hang = 1'b1;
    v = '{1'b0, OP_DIV, 16'd9, 16'd3, 5'd0, 32'h0, 1'b0, 1'b1, TMO + 2};
    send(v);
    wait_idle();
    stub_hang = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mini_alu_16bit_sched.md
# mini_alu_16bit_sched

Command scheduler for the 16-bit mini ALU. It shares the ALU between two requesters using round-robin arbitration. It sequences every operation, including holding the opcode and pulsing the divider start for the multi-cycle DIV. It returns each result, tagged with the requester ID, on a single valid/ready response port. It sits directly in front of the ALU; the ALU has no other driver.

## Interface
Parameters:
- DIV_TIMEOUT, 32: maximum WAIT_DIV cycles before an error response (used only when timeout is compiled in).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester command valid (bit n = requester n).
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- req_op  in  2x8  per-requester opcode.
- req_data0  in  2x16  per-requester operand 0.
- req_data1  in  2x16  per-requester operand 1.
- req_shift  in  2x5  per-requester shift amount.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester that issued the command.
- rsp_result  out  32  ALU result.
- rsp_overflow  out  1  ALU overflow flag.
- rsp_err  out  1  illegal opcode or DIV timeout.
- alu_op  out  8  ALU opcode.
- alu_data0  out  16  ALU operand 0.
- alu_data1  out  16  ALU operand 1.
- alu_num_shift  out  5  ALU shift amount.
- alu_div_start  out  1  divider start pulse.
- alu_result  in  32  ALU registered result.
- alu_overflow  in  1  ALU registered overflow.
- alu_valid  in  1  ALU registered valid.

## Operation
- **States:** IDLE, ISSUE, CAPTURE, WAIT_DIV, RESP.
- **IDLE:**
  - If any req_valid is set, grant one requester and assert its req_ready in the same cycle.
  - Latch the granted requester's op, data0, data1, shift and ID.
  - Go to ISSUE, or go directly to RESP if the op is illegal.
- **Arbitration:** round-robin with priority pointer `last_grant`. The other requester wins when both are valid. The pointer updates only on a grant. Reset value: requester 0 has priority.
- **Legal ops:** 8'h01–8'h0F. Illegal ops never reach the ALU; they respond with rsp_err=1, rsp_result=0, rsp_overflow=0.
- **ISSUE (1 cycle):**
  - Drive alu_op and operands from the latched command.
  - If op = 8'h04 (DIV), pulse alu_div_start=1 for exactly this cycle and go to WAIT_DIV.
  - Otherwise go to CAPTURE.
- **CAPTURE:**
  - Keep driving the same command.
  - Register alu_result and alu_overflow into the response registers; rsp_err=0.
  - Go to RESP.
- **WAIT_DIV:**
  - Hold alu_op=8'h04 and the operands.
  - On alu_valid=1, capture the result and overflow and go to RESP.
  - A zero divisor is not special-cased: the ALU overflow flag passes through.
- **RESP:**
  - Assert rsp_valid and hold all rsp_* fields stable until rsp_ready=1.
  - Then go to IDLE. No new grant is made in that same cycle.
- **ALU drive when idle:** in IDLE and RESP, alu_op=8'h00, operands=0 and alu_div_start=0.
- **Outstanding commands:** only one command is in flight at a time.

## Timing
- **Reset values:** req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, rsp_err=0, alu_op=0, alu_data0/1=0, alu_num_shift=0, alu_div_start=0. State=IDLE, pointer=requester 0.
- **Reset mid-operation:** abandon the command immediately. No response is ever produced for it.
- **Non-DIV op:** accept in cycle A, ISSUE in A+1, CAPTURE in A+2, rsp_valid high from A+3.
- **DIV op:** alu_div_start in cycle I, alu_valid seen in I+18, rsp_valid high from I+19.
- **Illegal op:** rsp_valid high in A+1.
- **Throughput:** with rsp_ready held high, the next accept is one cycle after the response handshake.
- **Backpressure:** rsp_ready low stalls RESP indefinitely; req_ready stays 0 throughout.

## Configuration
- **Macro:** MINI_ALU_SCHED_TIMEOUT_EN.
- **Defined:**
  - A counter clears in ISSUE and increments each WAIT_DIV cycle.
  - If the counter reaches DIV_TIMEOUT-1 with alu_valid=0, go to RESP with rsp_err=1, rsp_result=0, rsp_overflow=0.
  - alu_valid arriving in the same cycle as expiry wins.
- **Undefined:** no counter; WAIT_DIV waits indefinitely for alu_valid.

## Structure
- **Package mini_alu_pkg:** opcode constants (ADD..CMP, NOP=8'h00), the scheduler state enum, OP_DIV, and DIV_LATENCY=18.
- **Sub-module rr_arb_2:** two-way round-robin arbiter with one-hot grant and an internal pointer, updated on an accept-enable input.

## Test plan
- Requester 0 issues ADD 16'h0003+16'h0004 with rsp_ready=1 → rsp_result=32'h0000_0007, rsp_id=0, rsp_overflow=0, rsp_valid in A+3.
- Requester 1 issues DIV 100/7 → alu_div_start exactly one cycle; rsp_result={16'd14,16'd2}; rsp_valid in I+19.
- Both requesters valid continuously with MUL commands → grants alternate 0,1,0,1; requester 1 MUL 16'hFFFF×16'hFFFF returns 32'hFFFE_0001.
- Opcode 8'h20 → alu_op stays 0, rsp_err=1, rsp_result=0, rsp_valid in A+1.
- rsp_ready held low 10 cycles after SUB 5−9 → rsp_valid and fields stable throughout (rsp_result=4, rsp_overflow=1); req_ready=0; accept resumes after the handshake.
- rst asserted in WAIT_DIV → all outputs at reset values next cycle, no response; with the macro defined and an ALU stub never asserting valid, rsp_err=1 after DIV_TIMEOUT cycles.
